// File: rtl/axil_reg_map_v2.sv
// axil_reg_map_v2: AXI4-Lite slave that decodes one address segment onto a generic register-bank port
//   axilite_clk, axilite_rstb : clock, asynchronous active-low reset
//   s_axil_aw*, s_axil_w*     : write address / write data channels (one-beat holding register each)
//   s_axil_b*                 : write response (OKAY on segment hit, SLVERR on miss)
//   s_axil_ar*, s_axil_r*     : read address / read data channels (SLVERR on miss or timeout)
//   reg_wren, reg_rden        : one-cycle write strobe / read request to the register bank
//   reg_offset, reg_wdata, reg_wstrb : word-aligned byte offset, write data, byte strobes
//   reg_rdata, reg_rvalid     : bank read data, valid in the request cycle or later
module axil_reg_map_v2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int OFFSET_BITS = 16,
    parameter logic [ADDR_WIDTH-OFFSET_BITS-1:0] ADDR_SEGMENT = '0,
    parameter int RD_TIMEOUT = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   axilite_clk,
    input  logic                   axilite_rstb,
    input  logic [ADDR_WIDTH-1:0]  s_axil_awaddr,
    input  logic [2:0]             s_axil_awprot,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [DATA_WIDTH-1:0]  s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]  s_axil_wstrb,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    output logic [1:0]             s_axil_bresp,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]  s_axil_araddr,
    input  logic [2:0]             s_axil_arprot,
    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    output logic [DATA_WIDTH-1:0]  s_axil_rdata,
    output logic [1:0]             s_axil_rresp,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic                   reg_wren,
    output logic                   reg_rden,
    output logic [OFFSET_BITS-1:0] reg_offset,
    output logic [DATA_WIDTH-1:0]  reg_wdata,
    output logic [STRB_WIDTH-1:0]  reg_wstrb,
    input  logic [DATA_WIDTH-1:0]  reg_rdata,
    input  logic                   reg_rvalid
);
    localparam int ALIGN = $clog2(STRB_WIDTH);
    localparam logic [OFFSET_BITS-1:0] OFF_MASK = {{(OFFSET_BITS-ALIGN){1'b1}}, {ALIGN{1'b0}}};
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [7:0] CNT_LAST = 8'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RRESP} state_t;

    state_t                  state;
    logic                    aw_held, w_held, ar_held, prio, hit;
    logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_WIDTH-1:0]   w_strb;
    logic [7:0]              cnt;
    logic                    aw_hs, w_hs, ar_hs, aw_held_n, w_held_n, ar_held_n;
    logic                    go_wr, go_rd, aw_hit, ar_hit, rd_end, unused;
    logic [ADDR_WIDTH-1:0]   aw_a, ar_a;
    logic [DATA_WIDTH-1:0]   w_d;
    logic [STRB_WIDTH-1:0]   w_s;

    // A beat arriving this cycle counts as held, so dispatch costs no extra cycle.
    // prio=0 favours writes, prio=1 favours reads.
    always_comb begin
        unused    = ^{s_axil_awprot, s_axil_arprot};
        aw_hs     = s_axil_awvalid && s_axil_awready;
        w_hs      = s_axil_wvalid && s_axil_wready;
        ar_hs     = s_axil_arvalid && s_axil_arready;
        aw_a      = aw_held ? aw_addr : s_axil_awaddr;
        w_d       = w_held ? w_data : s_axil_wdata;
        w_s       = w_held ? w_strb : s_axil_wstrb;
        ar_a      = ar_held ? ar_addr : s_axil_araddr;
        aw_hit    = aw_a[ADDR_WIDTH-1:OFFSET_BITS] == ADDR_SEGMENT;
        ar_hit    = ar_a[ADDR_WIDTH-1:OFFSET_BITS] == ADDR_SEGMENT;
        go_wr     = state == IDLE && (aw_held || aw_hs) && (w_held || w_hs) && (!(ar_held || ar_hs) || !prio);
        go_rd     = state == IDLE && (ar_held || ar_hs) && !go_wr;
        aw_held_n = (aw_held || aw_hs) && state != WR;
        w_held_n  = (w_held || w_hs) && state != WR;
        ar_held_n = (ar_held || ar_hs) && state != RD;
        rd_end    = state == RWAIT && (reg_rvalid || cnt == CNT_LAST);
    end

    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            state          <= IDLE;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            ar_held        <= 1'b0;
            prio           <= 1'b0;
            hit            <= 1'b0;
            aw_addr        <= '0;
            ar_addr        <= '0;
            w_data         <= '0;
            w_strb         <= '0;
            cnt            <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_arready <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= '0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= '0;
            s_axil_rdata   <= '0;
            reg_wren       <= 1'b0;
            reg_rden       <= 1'b0;
            reg_offset     <= '0;
            reg_wdata      <= '0;
            reg_wstrb      <= '0;
        end else begin
            aw_held        <= aw_held_n;
            w_held         <= w_held_n;
            ar_held        <= ar_held_n;
            s_axil_awready <= !aw_held_n;
            s_axil_wready  <= !w_held_n;
            s_axil_arready <= !ar_held_n;
            if (aw_hs) aw_addr <= s_axil_awaddr;
            if (w_hs) begin
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            if (ar_hs) ar_addr <= s_axil_araddr;
            reg_wren <= go_wr && aw_hit;
            reg_rden <= go_rd && ar_hit;
            if (go_wr) begin
                state      <= WR;
                prio       <= 1'b1;
                hit        <= aw_hit;
                reg_offset <= aw_a[OFFSET_BITS-1:0] & OFF_MASK;
                reg_wdata  <= w_d;
                reg_wstrb  <= w_s;
            end else if (go_rd) begin
                state      <= RD;
                prio       <= 1'b0;
                hit        <= ar_hit;
                reg_offset <= ar_a[OFFSET_BITS-1:0] & OFF_MASK;
            end
            case (state)
                WR: begin
                    s_axil_bvalid <= 1'b1;
                    s_axil_bresp  <= hit ? OKAY : SLVERR;
                    state         <= WRESP;
                end
                WRESP: if (s_axil_bready) begin
                    s_axil_bvalid <= 1'b0;
                    state         <= IDLE;
                end
                RD: begin
                    cnt <= '0;
                    if (hit && !reg_rvalid) state <= RWAIT;
                    else begin
                        s_axil_rvalid <= 1'b1;
                        s_axil_rdata  <= hit ? reg_rdata : '0;
                        s_axil_rresp  <= hit ? OKAY : SLVERR;
                        state         <= RRESP;
                    end
                end
                RWAIT: begin
                    cnt <= cnt + 8'd1;
                    if (rd_end) begin
                        s_axil_rvalid <= 1'b1;
                        s_axil_rdata  <= reg_rvalid ? reg_rdata : '0;
                        s_axil_rresp  <= reg_rvalid ? OKAY : SLVERR;
                        state         <= RRESP;
                    end
                end
                RRESP: if (s_axil_rready) begin
                    s_axil_rvalid <= 1'b0;
                    state         <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_reg_map_v2.sv
// tb_axil_reg_map_v2: scoreboard bench for axil_reg_map_v2 with directed vectors and cycle-exact expectations
module tb_axil_reg_map_v2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OB = 16;
    localparam int SW = 4;
    localparam int TO = 4;

    typedef struct { int cyc; logic [OB-1:0] off; logic [DW-1:0] data; logic [SW-1:0] strb; } wr_t;
    typedef struct { int cyc; logic [OB-1:0] off; } rd_t;
    typedef struct { int cyc; logic [1:0] resp; } b_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic [1:0] resp; } r_t;

    logic clk = 0;
    logic rstb = 0;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0, rdata, reg_wdata, reg_rdata = '0;
    logic [SW-1:0] wstrb = '0, reg_wstrb;
    logic [2:0]    prot = '0;
    logic          awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1, reg_rvalid = 0;
    logic          awready, wready, arready, bvalid, rvalid, reg_wren, reg_rden;
    logic [1:0]    bresp, rresp;
    logic [OB-1:0] reg_offset;

    int cyc = 0, total = 0, passed = 0, hs, lat_cfg = -1;
    logic [DW-1:0] rsp_data = '0;
    wr_t wr_q[$];
    rd_t rd_q[$];
    b_t  b_q[$];
    r_t  r_q[$];
    wr_t wr_e;
    rd_t rd_e;
    b_t  b_e;
    r_t  r_e;

    axil_reg_map_v2 #(.RD_TIMEOUT(TO)) dut (
        .axilite_clk(clk), .axilite_rstb(rstb),
        .s_axil_awaddr(awaddr), .s_axil_awprot(prot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(prot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .reg_wren(reg_wren), .reg_rden(reg_rden), .reg_offset(reg_offset), .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents the selected beats now; returns one cycle after the last handshake (hs = handshake cycle).
    task automatic send(input bit a, input bit w, input bit r, input logic [AW-1:0] aa, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [AW-1:0] ra, output int h);
        bit da, dw, dr;
        da = !a;
        dw = !w;
        dr = !r;
        awaddr = aa;
        wdata = d;
        wstrb = s;
        araddr = ra;
        awvalid = a;
        wvalid = w;
        arvalid = r;
        h = -1;
        for (int i = 0; i < 20 && !(da && dw && dr); i++) begin
            @(negedge clk);
            if (awvalid && awready) da = 1;
            if (wvalid && wready) dw = 1;
            if (arvalid && arready) dr = 1;
            h = cyc;
            @(posedge clk);
            #1;
            awvalid = awvalid && !da;
            wvalid = wvalid && !dw;
            arvalid = arvalid && !dr;
        end
        chk("send_handshake", 128'({da, dw, dr}), 128'(3'b111));
        awvalid = 0;
        wvalid = 0;
        arvalid = 0;
    endtask

    // Register-bank model: answers each read request after lat_cfg cycles (never when negative).
    initial forever begin
        @(negedge clk);
        if (reg_rden && lat_cfg >= 0) begin
            if (lat_cfg > 0) begin
                repeat (lat_cfg) @(posedge clk);
                #1;
            end
            reg_rdata = rsp_data;
            reg_rvalid = 1;
            @(posedge clk);
            #1;
            reg_rvalid = 0;
            reg_rdata = '0;
        end
    end

    always @(negedge clk) begin
        if (reg_wren || reg_rden) chk("wren_rden_exclusive", 128'(reg_wren & reg_rden), 128'(0));
        if (reg_wren) begin
            if (wr_q.size() == 0) chk("unexpected_wren", 128'(reg_wren), 128'(0));
            else begin
                wr_e = wr_q.pop_front();
                chk("reg_write", 128'({cyc, reg_offset, reg_wdata, reg_wstrb}), 128'({wr_e.cyc, wr_e.off, wr_e.data, wr_e.strb}));
            end
        end
        if (reg_rden) begin
            if (rd_q.size() == 0) chk("unexpected_rden", 128'(reg_rden), 128'(0));
            else begin
                rd_e = rd_q.pop_front();
                chk("reg_read", 128'({cyc, reg_offset}), 128'({rd_e.cyc, rd_e.off}));
            end
        end
        if (bvalid && bready) begin
            if (b_q.size() == 0) chk("unexpected_bvalid", 128'(bvalid), 128'(0));
            else begin
                b_e = b_q.pop_front();
                chk("b_resp", 128'({cyc, bresp}), 128'({b_e.cyc, b_e.resp}));
            end
        end
        if (rvalid && rready) begin
            if (r_q.size() == 0) chk("unexpected_rvalid", 128'(rvalid), 128'(0));
            else begin
                r_e = r_q.pop_front();
                chk("r_resp", 128'({cyc, rdata, rresp}), 128'({r_e.cyc, r_e.data, r_e.resp}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int lats[5] = '{0, 3, 4, 5, -1};
        logic [DW-1:0] dats[5] = '{32'hCAFEF00D, 32'h12345678, 32'h0BADCAFE, 32'h55555555, 32'h66666666};
        logic [AW-1:0] adrs[5] = '{32'h20, 32'h24, 32'h1002, 32'h30, 32'h34};
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'({awready, wready, arready}), 128'(0));
        chk("rst_valid", 128'({bvalid, rvalid, bresp, rresp}), 128'(0));
        chk("rst_reg", 128'({reg_wren, reg_rden, reg_offset, reg_wdata, reg_wstrb}), 128'(0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        rstb = 1;
        @(negedge clk);
        chk("ready_after_rst", 128'({awready, wready, arready}), 128'(3'b111));
        @(posedge clk);
        #1;
        // write hit, AW and W together
        send(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, hs);
        wr_q.push_back('{hs + 1, 16'h0010, 32'hDEADBEEF, 4'hF});
        b_q.push_back('{hs + 2, 2'b00});
        goto(hs + 6);
        // zero strobes pass through; top offset is word-aligned
        send(1, 1, 0, 32'h0000_FFFF, 32'h00000001, 4'h0, 0, hs);
        wr_q.push_back('{hs + 1, 16'hFFFC, 32'h00000001, 4'h0});
        b_q.push_back('{hs + 2, 2'b00});
        goto(hs + 6);
        // split write: W first, AW three cycles later
        send(0, 1, 0, 0, 32'hA5A50001, 4'h3, 0, hs);
        @(negedge clk);
        chk("split_wready_held", 128'(wready), 128'(0));
        @(negedge clk);
        chk("split_wready_held", 128'(wready), 128'(0));
        goto(hs + 3);
        send(1, 0, 0, 32'h6, 0, 0, 0, hs);
        wr_q.push_back('{hs + 1, 16'h0004, 32'hA5A50001, 4'h3});
        b_q.push_back('{hs + 2, 2'b00});
        goto(hs + 6);
        // segment miss, write then read
        send(1, 1, 0, 32'h0001_0000, 32'h11112222, 4'hF, 0, hs);
        b_q.push_back('{hs + 2, 2'b10});
        goto(hs + 6);
        send(0, 0, 1, 0, 0, 0, 32'h0001_0000, hs);
        r_q.push_back('{hs + 2, 32'h0, 2'b10});
        goto(hs + 6);
        // read wait states and timeout at RD_TIMEOUT
        for (int i = 0; i < 5; i++) begin
            lat_cfg = lats[i];
            rsp_data = dats[i];
            send(0, 0, 1, 0, 0, 0, adrs[i], hs);
            rd_q.push_back('{hs + 1, adrs[i][OB-1:0] & 16'hFFFC});
            if (lats[i] < 0 || lats[i] > TO) r_q.push_back('{hs + 2 + TO, 32'h0, 2'b10});
            else r_q.push_back('{hs + 2 + lats[i], dats[i], 2'b00});
            goto(hs + 12);
        end
        // fresh reset: simultaneous write and read, write wins, bready held low
        rstb = 0;
        @(negedge clk);
        rstb = 1;
        @(negedge clk);
        goto(cyc + 1);
        lat_cfg = 0;
        rsp_data = 32'h77778888;
        bready = 0;
        send(1, 1, 1, 32'h40, 32'h600DF00D, 4'hF, 32'h44, hs);
        wr_q.push_back('{hs + 1, 16'h0040, 32'h600DF00D, 4'hF});
        b_q.push_back('{hs + 12, 2'b00});
        rd_q.push_back('{hs + 14, 16'h0044});
        r_q.push_back('{hs + 15, 32'h77778888, 2'b00});
        repeat (3) @(negedge clk);
        chk("bvalid_held", 128'(bvalid), 128'(1));
        chk("ar_captured_waiting", 128'(arready), 128'(0));
        goto(hs + 12);
        bready = 1;
        goto(hs + 20);
        // after a write dispatch, read has priority
        send(1, 1, 0, 32'h50, 32'h00000001, 4'hF, 0, hs);
        wr_q.push_back('{hs + 1, 16'h0050, 32'h00000001, 4'hF});
        b_q.push_back('{hs + 2, 2'b00});
        goto(hs + 6);
        rsp_data = 32'h3333CCCC;
        send(1, 1, 1, 32'h54, 32'h00002222, 4'hF, 32'h58, hs);
        rd_q.push_back('{hs + 1, 16'h0058});
        r_q.push_back('{hs + 2, 32'h3333CCCC, 2'b00});
        wr_q.push_back('{hs + 4, 16'h0054, 32'h00002222, 4'hF});
        b_q.push_back('{hs + 5, 2'b00});
        goto(hs + 10);
        // reset while waiting on a read, with an AW beat held
        lat_cfg = -1;
        send(0, 0, 1, 0, 0, 0, 32'h60, hs);
        rd_q.push_back('{hs + 1, 16'h0060});
        goto(hs + 3);
        awaddr = 32'h70;
        awvalid = 1;
        @(posedge clk);
        #1;
        awvalid = 0;
        #2;
        rstb = 0;
        #1;
        chk("rst_async_clear", 128'({rvalid, reg_rden, awready, wready, arready}), 128'(0));
        @(negedge clk);
        rstb = 1;
        @(negedge clk);
        chk("rst_mid_read_ready", 128'({awready, wready, arready}), 128'(3'b111));
        goto(cyc + 1);
        lat_cfg = 0;
        rsp_data = 32'h9999AAAA;
        send(0, 0, 1, 0, 0, 0, 32'h64, hs);
        rd_q.push_back('{hs + 1, 16'h0064});
        r_q.push_back('{hs + 2, 32'h9999AAAA, 2'b00});
        goto(hs + 12);
        chk("wr_q_drained", 128'(wr_q.size()), 128'(0));
        chk("rd_q_drained", 128'(rd_q.size()), 128'(0));
        chk("b_q_drained", 128'(b_q.size()), 128'(0));
        chk("r_q_drained", 128'(r_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
